auto_pq_ctrl: RTL

AUTO_PQ_CTRL -- requirements
Module: auto_pq_ctrl

---
 rtl/pq_pkg.sv | 35 +++
 rtl/pq_regarray.sv | 91 +++++++++
 rtl/auto_pq_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// Shared types and constants for the auto priority-queue controller:
// FSM state encoding, LFSR seed/taps, per-state RGB codes.
package pq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_ADD     = 3'd2,
    ST_REMOVE  = 3'd3,
    ST_DISPLAY = 3'd4
  } state_e;

  // 16-bit Galois LFSR, x^16 + x^14 + x^13 + x^11, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam rgb_t RGB_IDLE      = {3'd0, 3'd0, 3'd7};
  localparam rgb_t RGB_START     = {3'd7, 3'd7, 3'd7};
  localparam rgb_t RGB_ADD       = {3'd0, 3'd7, 3'd0};
  localparam rgb_t RGB_REMOVE    = {3'd7, 3'd0, 3'd0};
  localparam rgb_t RGB_DISP_FULL = {3'd7, 3'd7, 3'd0};
  localparam rgb_t RGB_OFF       = {3'd0, 3'd0, 3'd0};

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pq_regarray.sv
// Sorted register array: entry 0 always holds the minimum key. An inserted
// key lands behind any equal keys already stored, so ties leave in arrival
// order. Slots at or above count are kept at zero.
module pq_regarray
  import pq_pkg::*;
#(
  parameter int KW    = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ins,
  input  logic                         rem,
  input  logic [KW-1:0]                key_in,
  output logic [KW-1:0]                key_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH+1);

  logic [KW-1:0]             mem_q [DEPTH];
  logic [DEPTH-1:0][KW-1:0]  mem_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0]          valid;
  logic [DEPTH-1:0]          keep;
  logic                      do_ins, do_rem;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_ins  = ins && !full;
  assign do_rem  = rem && !ins && !empty;
  assign key_out = mem_q[0];
  assign count   = count_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [KW-1:0] below_key, above_key;
    logic          below_keep, below_valid;

    // A slot keeps its key on insert when it is occupied and not larger than the new key.
    assign valid[gi] = (CW'(gi) < count_q);
    assign keep[gi]  = valid[gi] && !(mem_q[gi] > key_in);

    if (gi == 0) begin : g_first
      assign below_key   = '0;
      assign below_keep  = 1'b1;
      assign below_valid = 1'b0;
    end else begin : g_rest
      assign below_key   = mem_q[gi-1];
      assign below_keep  = keep[gi-1];
      assign below_valid = valid[gi-1];
    end

    if (gi == DEPTH-1) begin : g_last
      assign above_key = '0;
    end else begin : g_inner
      assign above_key = mem_q[gi+1];
    end

    // Insert: first non-kept slot takes the key, occupied slots above shift up.
    // Remove: everything shifts toward the head, zero enters at the top.
    assign mem_d[gi] = do_ins ? (keep[gi]    ? mem_q[gi] :
                                 below_keep  ? key_in    :
                                 below_valid ? below_key : mem_q[gi])
                     : do_rem ? above_key
                     : mem_q[gi];
  end

  // Occupancy follows the accepted operation.
  always_comb begin
    count_d = count_q;
    if (do_ins) begin
      count_d = count_q + CW'(1);
    end else if (do_rem) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage and occupancy registers, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/auto_pq_ctrl.sv
// Self-running priority-queue demo: inserts pseudo-random keys and removes
// minima in either fill-then-drain or add-add-remove order, holding each
// result on display for HOLD_CYCLES cycles.
module auto_pq_ctrl
  import pq_pkg::*;
#(
  parameter int KW          = 4,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  output logic [KW-1:0]                data1,
  output logic [KW-1:0]                data2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [2:0]                   red,
  output logic [2:0]                   green,
  output logic [2:0]                   blue,
  output logic                         sigIDLE,
  output logic                         sigSTART,
  output logic                         sigADD,
  output logic                         sigREMOVE,
  output logic                         sigDISPLAY,
  output logic                         sigFULL,
  output logic                         sigEMPTY
);

  localparam int            DW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [1:0]    phase_q, phase_d, phase_step;
  logic          drain_q, drain_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [KW-1:0] data1_q, data1_d;
  logic [KW-1:0] data2_q, data2_d;

  logic          pq_ins, pq_rem, pq_full, pq_empty;
  logic [KW-1:0] pq_key_out;
  rgb_t          rgb;

  pq_regarray #(
    .KW    (KW),
    .DEPTH (DEPTH)
  ) u_regarray (
    .clk     (clk),
    .rst     (rst),
    .ins     (pq_ins),
    .rem     (pq_rem),
    .key_in  (lfsr_q[KW-1:0]),
    .key_out (pq_key_out),
    .count   (count),
    .full    (pq_full),
    .empty   (pq_empty)
  );

  // Phase walks 0,1,2 so that interleaved mode does ADD, ADD, REMOVE.
  assign phase_step = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
  assign lfsr_d     = lfsr_step(lfsr_q);

  // Next-state logic; the queue decision is taken on the last DISPLAY cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    drain_d = drain_q;
    dwell_d = dwell_q;
    data1_d = data1_q;
    data2_d = data2_q;
    pq_ins  = 1'b0;
    pq_rem  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_START;
      end
      ST_START: begin
        mode_d  = mode;
        phase_d = 2'd0;
        drain_d = 1'b0;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        pq_ins  = 1'b1;
        data2_d = lfsr_q[KW-1:0];
        phase_d = phase_step;
        dwell_d = '0;
        state_d = ST_DISPLAY;
      end
      ST_REMOVE: begin
        pq_rem  = 1'b1;
        data1_d = pq_key_out;
        phase_d = phase_step;
        dwell_d = '0;
        state_d = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (drain_q || pq_full) begin
            // Once the queue has filled, only removals remain until empty.
            drain_d = 1'b1;
            state_d = pq_empty ? ST_IDLE : ST_REMOVE;
          end else if (!mode_q || phase_q != 2'd2 || pq_empty) begin
            state_d = ST_ADD;
          end else begin
            state_d = ST_REMOVE;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; the LFSR free-runs whenever out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      phase_q <= 2'd0;
      drain_q <= 1'b0;
      dwell_q <= '0;
      lfsr_q  <= LFSR_SEED;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      dwell_q <= dwell_d;
      lfsr_q  <= lfsr_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  // State indicators and RGB colour decoded from the current state.
  always_comb begin
    rgb        = RGB_OFF;
    sigIDLE    = 1'b0;
    sigSTART   = 1'b0;
    sigADD     = 1'b0;
    sigREMOVE  = 1'b0;
    sigDISPLAY = 1'b0;
    case (state_q)
      ST_IDLE:    begin sigIDLE   = 1'b1; rgb = RGB_IDLE;   end
      ST_START:   begin sigSTART  = 1'b1; rgb = RGB_START;  end
      ST_ADD:     begin sigADD    = 1'b1; rgb = RGB_ADD;    end
      ST_REMOVE:  begin sigREMOVE = 1'b1; rgb = RGB_REMOVE; end
      ST_DISPLAY: begin
        sigDISPLAY = 1'b1;
        rgb        = pq_full ? RGB_DISP_FULL : RGB_OFF;
      end
      default:    begin sigIDLE   = 1'b1; rgb = RGB_IDLE;   end
    endcase
  end

  assign data1    = data1_q;
  assign data2    = data2_q;
  assign red      = rgb.r;
  assign green    = rgb.g;
  assign blue     = rgb.b;
  assign sigFULL  = pq_full;
  assign sigEMPTY = pq_empty;

endmodule
